bcd_mul_seq: RTL

Multi-cycle BCD multiplier controller for the calculator datapath. It takes two 8-digit unsigned BCD operands and sequences one 32-bit BCD adder through a digit-serial shift-and-add loop. It produces an 8-digit BCD product together with overflow and error flags, and uses a start/busy/done handshake. The calculator top level drives it on its multiply op key, supplies magnitudes only (sign handled outside), and latches the result into saved when done pulses.

---
 rtl/calc_pkg.sv | 61 ++++++
 rtl/bcd_add32c.sv | 64 ++++++
 rtl/bcd_mul_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator datapath: operand sizing, the BCD
// digit limit, the multiplier FSM encoding and the calculator key/op codes.
// Also carries a helper that flags operands holding non-decimal nibbles.
// ---------------------------------------------------------------------------
package calc_pkg;

    // Operand / result sizing
    localparam int DIGITS = 8;
    localparam int WIDTH  = 4 * DIGITS;

    // Largest legal value of one BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Number of multiplier digits processed per multiply
    localparam logic [3:0] POS_INIT = 4'(DIGITS);

    // Multiplier FSM encoding, kept as plain constants for legacy users
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ADD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Same encoding as an enum for debug/waveform readability
    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        ADD   = ST_ADD,
        DONE  = ST_DONE
    } state_e;

    // Calculator operations; OP_MUL selects the sequential multiplier
    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3
    } calc_op_e;

    // Keypad codes for the operator keys
    localparam logic [4:0] KEY_PLUS   = 5'h10;
    localparam logic [4:0] KEY_MINUS  = 5'h11;
    localparam logic [4:0] KEY_EQUALS = 5'h12;
    localparam logic [4:0] KEY_MUL    = 5'h13;

    // True when any nibble of v is above 9
    function automatic logic bcd_invalid(input logic [WIDTH-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > BCD_MAX) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_add32c.sv
// ---------------------------------------------------------------------------
// bcd_add32c
// Ripple-carry BCD adder over DIGITS decimal digits, carry-in tied to 0.
// Ports:
//   x, y  : BCD addends (4*DIGITS bits, digits assumed valid)
//   sum   : BCD sum modulo 10^DIGITS
//   cout  : decimal carry out of the most significant digit
// ---------------------------------------------------------------------------
module bcd_add_cell (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] raw_s;
    logic [4:0] fix_s;

    assign raw_s = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    // Adding 6 skips the six unused codes 10..15 and wraps the digit
    assign fix_s = raw_s + 5'd6;

    // Decimal correction of one digit
    always_comb begin
        s    = raw_s[3:0];
        cout = 1'b0;
        if (raw_s > 5'd9) begin
            s    = fix_s[3:0];
            cout = 1'b1;
        end else begin
            s    = raw_s[3:0];
            cout = 1'b0;
        end
    end

endmodule

module bcd_add32c
    import calc_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [DIGITS:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add_cell u_cell (
            .x    (x[4*i +: 4]),
            .y    (y[4*i +: 4]),
            .cin  (carry_s[i]),
            .s    (sum[4*i +: 4]),
            .cout (carry_s[i+1])
        );
    end

    assign cout = carry_s[DIGITS];

endmodule

// File: rtl/bcd_mul_seq.sv
// ---------------------------------------------------------------------------
// bcd_mul_seq
// Sequential 8-digit BCD multiplier. Walks the multiplier from its most
// significant digit: shift the running product one digit left, then add the
// multiplicand as many times as the current multiplier digit says.
// Ports:
//   hz100  : clock, all state on rising edge
//   reset  : asynchronous active-low reset
//   start  : begin a multiply (only honoured in IDLE)
//   abort  : cancel an operation in progress, no done pulse
//   a, b   : multiplicand / multiplier, 8 BCD digits each
//   busy   : high in every state except IDLE
//   done   : one-cycle pulse with the final result
//   result : low 8 digits of the product, held until the next done
//   ovf    : product did not fit in 8 digits
//   err    : an operand had a nibble above 9
// ---------------------------------------------------------------------------
module bcd_mul_seq
    import calc_pkg::*;
(
    input  logic             hz100,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             err
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [3:0]       dcnt_r;
    logic [3:0]       pos_r;
    logic             ovf_wk_r;
    logic             err_wk_r;
    logic [WIDTH-1:0] result_r;
    logic             ovf_hold_r;
    logic             err_hold_r;
    logic [WIDTH-1:0] sum_s;
    logic             carry_s;
    logic             abort_s;
    logic             bad_op_s;
    logic             done_s;

    bcd_add32c u_add (
        .x    (acc_r),
        .y    (mcand_r),
        .sum  (sum_s),
        .cout (carry_s)
    );

    // abort only counts while an operation is in flight
    assign abort_s  = abort & (state_r != ST_IDLE);
    assign bad_op_s = bcd_invalid(a) | bcd_invalid(b);
    // done is cut combinationally so an abort in DONE never shows a pulse
    assign done_s   = (state_r == ST_DONE) & ~abort;

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = bad_op_s ? ST_DONE : ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    state_nxt_s = ST_ADD;
                end
                ST_ADD: begin
                    // dcnt==0 costs one cycle even for a zero digit
                    if (dcnt_r != 4'd0) begin
                        state_nxt_s = ST_ADD;
                    end else if (pos_r == 4'd0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift-and-add datapath; frozen on abort since the work is discarded
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            dcnt_r   <= 4'd0;
            pos_r    <= 4'd0;
            ovf_wk_r <= 1'b0;
            err_wk_r <= 1'b0;
        end else if (abort_s) begin
            acc_r <= acc_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && bad_op_s) begin
                        acc_r    <= {WIDTH{1'b0}};
                        ovf_wk_r <= 1'b0;
                        err_wk_r <= 1'b1;
                    end else if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_r    <= {WIDTH{1'b0}};
                        pos_r    <= POS_INIT;
                        ovf_wk_r <= 1'b0;
                        err_wk_r <= 1'b0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_SHIFT: begin
                    // A nonzero top digit is about to fall off the product
                    if (acc_r[WIDTH-1 -: 4] != 4'd0) begin
                        ovf_wk_r <= 1'b1;
                    end else begin
                        ovf_wk_r <= ovf_wk_r;
                    end
                    acc_r    <= {acc_r[WIDTH-5:0], 4'd0};
                    dcnt_r   <= mplier_r[WIDTH-1 -: 4];
                    mplier_r <= {mplier_r[WIDTH-5:0], 4'd0};
                    pos_r    <= pos_r - 4'd1;
                end
                ST_ADD: begin
                    if (dcnt_r != 4'd0) begin
                        acc_r    <= sum_s;
                        ovf_wk_r <= ovf_wk_r | carry_s;
                        dcnt_r   <= dcnt_r - 4'd1;
                    end else begin
                        dcnt_r <= dcnt_r;
                    end
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Held copy of the last completed result, captured as DONE retires
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            result_r   <= {WIDTH{1'b0}};
            ovf_hold_r <= 1'b0;
            err_hold_r <= 1'b0;
        end else if (done_s) begin
            result_r   <= acc_r;
            ovf_hold_r <= ovf_wk_r;
            err_hold_r <= err_wk_r;
        end else begin
            result_r   <= result_r;
            ovf_hold_r <= ovf_hold_r;
            err_hold_r <= err_hold_r;
        end
    end

    // Output select: the fresh value during the done cycle, the held one otherwise
    always_comb begin
        busy = (state_r != ST_IDLE);
        done = done_s;
        if (done_s) begin
            result = acc_r;
            ovf    = ovf_wk_r;
            err    = err_wk_r;
        end else begin
            result = result_r;
            ovf    = ovf_hold_r;
            err    = err_hold_r;
        end
    end

endmodule
